// File: rtl/rv32_pkg.sv
// Shared RV32 encoding types: instruction formats, opcode constants and the
// registered request bundle used between the packer stages.
package rv32_pkg;

    typedef enum logic [2:0] {
        ENC_R,
        ENC_I,
        ENC_S,
        ENC_B,
        ENC_U,
        ENC_J
    } EncFmt_t;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;

    typedef struct packed {
        EncFmt_t     fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    // True when bits [31:msb] of v are all equal, i.e. v survives truncation to msb+1 signed bits.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((v & mask) == 32'h0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/inst_pack_enc.sv
// Combinational RV32I encoder: scatters immediate bits into the format-specific slots.
// Range flag is live only when INST_PACKER_RANGE_CHECK_EN is defined.
module inst_pack_enc
    import rv32_pkg::*;
(
    input  EncFmt_t     i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_err
);

    always_comb begin
        o_inst = 32'h0;
        case (i_fmt)
            ENC_R:   o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            ENC_I:   o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            ENC_S:   o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            ENC_B:   o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], i_opcode};
            ENC_U:   o_inst = {i_imm[31:12], i_rd, i_opcode};
            ENC_J:   o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            default: o_inst = 32'h0;
        endcase
    end

`ifdef INST_PACKER_RANGE_CHECK_EN
    always_comb begin
        o_err = 1'b0;
        case (i_fmt)
            ENC_I, ENC_S: o_err = !sext_fits(i_imm, 11);
            ENC_B:        o_err = !sext_fits(i_imm, 12) || i_imm[0];
            ENC_J:        o_err = !sext_fits(i_imm, 20) || i_imm[0];
            ENC_U:        o_err = |i_imm[11:0];
            default:      o_err = 1'b0;
        endcase
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: rtl/inst_packer.sv
// Two-stage valid/ready RV32I instruction packer, request-to-output 2 cycles; in_ready follows out_ready.
// INST_PACKER_RANGE_CHECK_EN enables out_err and the saturating err_cnt (otherwise both tie to 0).
module inst_packer
    import rv32_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  EncFmt_t              in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clr_err
);

    logic        r_s1_vld;
    enc_req_t    r_s1_req;
    logic        r_s2_vld;
    logic [31:0] r_inst;
    logic        r_err;

    enc_req_t    w_in_req;
    logic        w_s2_adv;
    logic        w_s1_adv;
    logic [31:0] w_inst;
    logic        w_err;

    assign w_in_req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                        funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    // Ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_s2_adv = !r_s2_vld || out_ready;
    assign w_s1_adv = w_s2_adv || !r_s1_vld;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_req <= '0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_req <= w_in_req;
            end
        end
    end

    inst_pack_enc u_enc (
        .i_fmt    (r_s1_req.fmt),
        .i_opcode (r_s1_req.opcode),
        .i_rd     (r_s1_req.rd),
        .i_rs1    (r_s1_req.rs1),
        .i_rs2    (r_s1_req.rs2),
        .i_funct3 (r_s1_req.funct3),
        .i_funct7 (r_s1_req.funct7),
        .i_imm    (r_s1_req.imm),
        .o_inst   (w_inst),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_inst   <= 32'h0;
            r_err    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_inst <= w_inst;
                r_err  <= w_err;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_inst  = r_inst;
    assign out_err   = r_err;

`ifdef INST_PACKER_RANGE_CHECK_EN
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Clear takes priority over a coincident errored handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= '0;
        end else if (r_s2_vld && out_ready && r_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_err;
    assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_inst_packer.sv
// Randomized + directed bench for inst_packer against a behavioural encoder/range model.
module tb_inst_packer;
    import rv32_pkg::*;

`ifdef INST_PACKER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    EncFmt_t     in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic        clr_err;

    always #5 clk = ~clk;

    inst_packer #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .err_cnt(err_cnt), .clr_err(clr_err)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   model_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back(rec_t'{out_inst, out_err, cyc});
    end

    // Reference encoding built by shifting each field to its architectural bit position.
    function automatic logic [31:0] model_inst(input EncFmt_t f, input logic [6:0] op,
                                               input logic [4:0] rd, rs1, rs2,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [31:0] imm);
        logic [31:0] r;
        r = 32'(op);
        case (f)
            ENC_R: r |= (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            ENC_I: r |= ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
            ENC_S: r |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                        | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
            ENC_B: r |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                        | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
                        | (((imm >> 11) & 32'h1) << 7);
            ENC_U: r |= (imm & 32'hFFFFF000) | (32'(rd) << 7);
            ENC_J: r |= (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic model_err(input EncFmt_t f, input logic [31:0] imm);
        int  s;
        logic bad;
        s = $signed(imm);
        case (f)
            ENC_I, ENC_S: bad = (s < -2048) || (s > 2047);
            ENC_B:        bad = (s < -4096) || (s > 4095) || imm[0];
            ENC_J:        bad = (s < -(1 << 20)) || (s > (1 << 20) - 1) || imm[0];
            ENC_U:        bad = (imm & 32'hFFF) != 32'h0;
            default:      bad = 1'b0;
        endcase
        return RC && bad;
    endfunction

    function automatic rec_t cur_exp();
        rec_t r;
        r.inst = model_inst(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        r.err  = model_err(in_fmt, in_imm);
        r.cyc  = cyc;
        return r;
    endfunction

    task automatic set_req(input EncFmt_t f, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Offers one request (called at posedge+1) and returns at posedge+1 after it is accepted.
    task automatic send(input EncFmt_t f, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        output bit ok);
        set_req(f, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(cur_exp());
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 600 && !ok; t++) begin
            if (obs_q.size() >= n) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got %h want 0", out_inst); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", out_err); else n_pass++;
        n_checks++; if (err_cnt !== 8'h0) $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        EncFmt_t     fa[4]   = '{ENC_I, ENC_B, ENC_J, ENC_U};
        logic [6:0]  opa[4]  = '{7'h13, 7'h63, 7'h6F, 7'h37};
        logic [4:0]  rda[4]  = '{5'd1, 5'd0, 5'd1, 5'd5};
        logic [31:0] imma[4] = '{32'd5, 32'hFFFFFFFC, 32'h800, 32'h12345000};
        logic [31:0] gold[4] = '{32'h00500093, 32'hFE000EE3, 32'h001000EF, 32'h123452B7};
        bit ok, ok2;
        rec_t e, o;
        for (int i = 0; i < 4; i++) begin
            send(fa[i], opa[i], rda[i], 5'd0, 5'd0, 3'd0, 7'd0, imma[i], ok);
            wait_obs(1, ok2);
            n_checks++; if (!(ok && ok2)) $display("FAIL directed_handshake[%0d] got accept=%b out=%b want 1 1", i, ok, ok2); else n_pass++;
            if (ok && ok2) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_checks++; if (o.inst !== gold[i]) $display("FAIL directed_inst[%0d] got %h want %h", i, o.inst, gold[i]); else n_pass++;
                n_checks++; if (o.err !== 1'b0) $display("FAIL directed_err[%0d] got %b want 0", i, o.err); else n_pass++;
                n_checks++; if (o.cyc - e.cyc !== 2) $display("FAIL directed_latency[%0d] got %0d want 2", i, o.cyc - e.cyc); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors();
        bit ok, ok2;
        rec_t e, o;
        pulse_clr();
        send(ENC_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, ok);
        wait_obs(1, ok2);
        @(posedge clk); #1;
        n_checks++; if (!(ok && ok2)) $display("FAIL lui_err_handshake got %b %b want 1 1", ok, ok2); else n_pass++;
        if (ok && ok2) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.inst !== 32'h123452B7 || o.err !== RC) $display("FAIL lui_err_out got %h/%b want %h/%b", o.inst, o.err, 32'h123452B7, RC); else n_pass++;
        end
        n_checks++; if (err_cnt !== 8'(RC ? 1 : 0)) $display("FAIL lui_err_cnt got %0d want %0d", err_cnt, RC ? 1 : 0); else n_pass++;

        pulse_clr();
        send(ENC_I, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, ok);
        send(ENC_B, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'd3, ok2);
        wait_obs(2, ok);
        @(posedge clk); #1;
        n_checks++; if (!ok) $display("FAIL ib_err_outputs got %0d want 2", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.inst !== e.inst || o.err !== RC) $display("FAIL ib_err_out got %h/%b want %h/%b", o.inst, o.err, e.inst, RC); else n_pass++;
        end
        n_checks++; if (err_cnt !== 8'(RC ? 2 : 0)) $display("FAIL ib_err_cnt got %0d want %0d", err_cnt, RC ? 2 : 0); else n_pass++;
        pulse_clr();
        n_checks++; if (err_cnt !== 8'h0) $display("FAIL clr_err_cnt got %0d want 0", err_cnt); else n_pass++;

        // Clear lands on the same edge as an errored handshake.
        pulse_clr();
        out_ready = 1'b0;
        send(ENC_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1, ok);
        for (int t = 0; t < 10 && !out_valid; t++) begin @(posedge clk); #1; end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL coinc_valid got %b want 1", out_valid); else n_pass++;
        out_ready = 1'b1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        n_checks++; if (err_cnt !== 8'h0) $display("FAIL coinc_err_cnt got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (obs_q.size() !== 1 || obs_q[0].err !== RC) $display("FAIL coinc_out got n=%0d want 1 errored", obs_q.size()); else n_pass++;
        exp_q.delete(); obs_q.delete();
        model_cnt = 0;
    endtask

    task automatic test_backpressure();
        int          idx = 0, accepts = 0;
        bit          stable_ok = 1'b1, have_ref = 1'b0, ok;
        logic [31:0] ref_inst = 32'h0;
        rec_t        e[3], o[3];
        out_ready = 1'b0;
        set_req(ENC_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin exp_q.push_back(cur_exp()); accepts++; idx++; end
            if (out_valid) begin
                if (have_ref && out_inst !== ref_inst) stable_ok = 1'b0;
                ref_inst = out_inst; have_ref = 1'b1;
            end
            @(posedge clk); #1;
            if (idx < 3) set_req(ENC_I, 7'h13, 5'(idx + 1), 5'(idx + 1), 5'd0, 3'd0, 7'd0, 32'(idx + 1));
            else in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (accepts !== 2) $display("FAIL bp_accepts got %0d want 2", accepts); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (!(stable_ok && have_ref && out_inst === ref_inst)) $display("FAIL bp_stable got %h want %h", out_inst, ref_inst); else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 10 && idx < 3; t++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin exp_q.push_back(cur_exp()); idx++; end
            @(posedge clk); #1;
            if (idx >= 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        wait_obs(3, ok);
        n_checks++; if (!ok || exp_q.size() != 3) $display("FAIL bp_outputs got %0d/%0d want 3", obs_q.size(), exp_q.size()); else n_pass++;
        if (ok && exp_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin e[i] = exp_q.pop_front(); o[i] = obs_q.pop_front(); end
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (o[i].inst !== e[i].inst || o[i].err !== e[i].err) $display("FAIL bp_order[%0d] got %h want %h", i, o[i].inst, e[i].inst); else n_pass++;
            end
            n_checks++; if (o[1].cyc !== o[0].cyc + 1 || o[2].cyc !== o[1].cyc + 1) $display("FAIL bp_consecutive got cycles %0d %0d %0d want consecutive", o[0].cyc, o[1].cyc, o[2].cyc); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit   done = 1'b0, ok;
        int   fails = 0, n = 0;
        rec_t e, o;
        pulse_clr();
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    EncFmt_t     f;
                    logic [31:0] imm;
                    f = EncFmt_t'(3'($urandom_range(0, 5)));
                    case ($urandom_range(0, 3))
                        0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                        1:       imm = $urandom;
                        2:       imm = $urandom & 32'hFFFFF000;
                        default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                    endcase
                    send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm, ok);
                    if (!ok) fails++;
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n_checks++; if (fails !== 0) $display("FAIL rand_accept got %0d stuck want 0", fails); else n_pass++;
        wait_obs(150, ok);
        @(posedge clk); #1;
        n_checks++; if (!ok) $display("FAIL rand_outputs got %0d want 150", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o.inst !== e.inst || o.err !== e.err) $display("FAIL rand_out[%0d] got %h/%b want %h/%b", n, o.inst, o.err, e.inst, e.err); else n_pass++;
            if (e.err && model_cnt < 255) model_cnt++;
            n++;
        end
        n_checks++; if (err_cnt !== 8'(model_cnt)) $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, model_cnt); else n_pass++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        bit ok;
        pulse_clr();
        for (int i = 0; i < 260; i++) send(ENC_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1, ok);
        wait_obs(260, ok);
        @(posedge clk); #1;
        n_checks++; if (!ok) $display("FAIL sat_outputs got %0d want 260", obs_q.size()); else n_pass++;
        n_checks++; if (err_cnt !== 8'(RC ? 255 : 0)) $display("FAIL sat_err_cnt got %0d want %0d", err_cnt, RC ? 255 : 0); else n_pass++;
        exp_q.delete(); obs_q.delete();
        pulse_clr();
    endtask

    task automatic test_reset_midflight();
        bit ok, ok2;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b0;
        send(ENC_I, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, ok);
        send(ENC_I, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10, ok2);
        n_checks++; if (!(ok && ok2 && out_valid === 1'b1)) $display("FAIL mid_inflight got valid=%b want 1", out_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b want 0", out_valid); else n_pass++;
        exp_q.delete();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL mid_ghost_outputs got %0d want 0", obs_q.size()); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (err_cnt !== 8'h0) $display("FAIL mid_err_cnt got %0d want 0", err_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_err = 1'b0;
        set_req(ENC_R, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
